nwrite_req_builder: RTL
=======================

// Module: nwrite_req_builder
// PURPOSE
//  Downstream of the 256-byte packetising input stage. Consumes its AXI-stream
//  packets (at most 256 B each) and buffers one whole packet. It then emits the
//  packet on the SRIO initiator-request (ireq) port as a HELLO-format NWRITE:
//  one header beat followed by the data beats.
//  Tracks destination address, TID and remaining byte count across a multi-packet transfer.
// PARAMETERS
//  DATA_WIDTH        64  stream data width in bits; fixed 64 for HELLO format
//  DATA_LENGTH_WIDTH 20  width of transfer length (bytes minus one)
//  ADDR_WIDTH        34  RapidIO address width
//  BUF_DEPTH         32  packet buffer depth in beats (256 B / 8 B)
// PORTS
//  clk            in   1      single clock
//  reset          in   1      synchronous, active-high
//  start_in       in   1      one-cycle pulse; latches base_addr_in, dest_id_in, len_in
//  base_addr_in   in   34     start address of transfer
//  dest_id_in     in   16     target device ID
//  src_id_in      in   16     local device ID
//  len_in         in   20     transfer bytes minus one
//  s_tdata        in   64     packet data from input stage
//  s_tkeep        in   8      byte enables; contiguous from bit 7 (MSB lane first)
//  s_tvalid       in   1      input beat valid
//  s_tlast        in   1      last beat of a <=256 B packet
//  s_tready       out  1      buffer can accept a beat
//  ireq_tdata     out  64     header or payload beat
//  ireq_tkeep     out  8      always 8'hFF
//  ireq_tvalid    out  1      beat valid
//  ireq_tlast     out  1      last payload beat of the NWRITE
//  ireq_tuser     out  32     {src_id, dest_id}
//  ireq_tready    in   1      SRIO core accepts beat
//  busy_o         out  1      transfer in progress
//  done_o         out  1      one-cycle pulse when final packet's tlast handshakes
// BEHAVIOUR
//  Reset (sync): state=IDLE; all outputs 0; ptrs, counters, TID=0.
//  FSM: IDLE -> (start_in) LOAD -> HDR -> DATA -> (more bytes) LOAD | (none) IDLE.
//  IDLE: s_tready=0.
//    start_in latches addr/dest/src and remaining=len_in+1 (21-bit). busy_o=1 from the next cycle.
//    start_in while busy is ignored.
//  LOAD: s_tready=1.
//    Each s_tvalid&s_tready beat is written to buf[wr_cnt]; beat_cnt increments.
//    byte_cnt += popcount(s_tkeep).
//    Exit to HDR on the cycle after the beat with s_tlast, or after the 32nd beat, whichever comes first.
//    A 32nd beat without s_tlast closes the packet; this is not an error.
//  HDR: ireq_tvalid=1, ireq_tlast=0.
//    ireq_tdata = {tid[7:0], 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, size[7:0], 2'b00, addr[33:0]}.
//    FTYPE=5, TTYPE=4, prio=1, crf=0.
//    size = byte_cnt-1 (8 bits; 256 B -> 8'hFF).
//    Advance to DATA on ireq_tready.
//  DATA: ireq_tdata=buf[rd_cnt]; ireq_tvalid=1; ireq_tlast=(rd_cnt==beat_cnt-1).
//    rd_cnt increments on each handshake.
//    When the tlast beat handshakes:
//      addr += byte_cnt
//      tid += 1 (8-bit wrap, 255->0)
//      remaining -= byte_cnt, saturating at 0
//      clear beat/byte counters
//    Then go to LOAD if the new remaining != 0. Otherwise go to IDLE, pulse done_o, and drop busy_o.
//  ireq_tvalid, once high, holds with stable tdata/tlast/tuser until ireq_tready; AXI rule, no retraction.
//  ireq_tuser = {src_id, dest_id}, constant for the whole transfer.
//  Latency: first header beat valid 1 cycle after the closing input beat.
//  No throughput overlap: LOAD and DATA are exclusive, so s_tready=0 in HDR/DATA.
//  Arithmetic:
//    addr wraps modulo 2^34.
//    byte_cnt is 9 bits (max 256).
//    remaining is 21 bits.
//  Input beat with s_tkeep==0 is stored and counted as a beat but adds 0 bytes.
//  reset asserted mid-transfer: abort immediately, to IDLE, buffer discarded, no done_o.
// TESTING
//  len_in=255, 32 full beats (tlast on 32nd), ready=1 -> 33 ireq beats.
//    Header size=8'hFF, addr=base, tid=0; data in order; done_o 1 cycle after tlast handshake.
//  len_in=1023, base=34'h1000 -> 4 NWRITEs.
//    Headers carry addr 1000/1100/1200/1300 and tid 0..3; single done_o after the 4th.
//  len_in=300: 32 beats, then 6 beats, last tkeep=8'hF0 -> second header size=8'h2B (44 B), addr=base+256.
//  Random ireq_tready stalls (~50%) -> tdata/tvalid/tlast stable while stalled; beat order and count unchanged.
//  tid starting at 255 (via 255 prior packets) -> next header tid=0.
//  reset pulsed during DATA of packet 2 -> outputs 0 next cycle; a new start_in then produces tid=0, addr=new base.

Source files
------------

// File: rtl/nwrite_req_builder.sv
// nwrite_req_builder: buffers one AXI-stream packet (<= 256 B) and replays it on the
// SRIO ireq port as a HELLO-format NWRITE (one header beat, then the payload beats).
// Destination address, TID and remaining byte count carry across the packets of a transfer.
module nwrite_req_builder #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned DATA_LENGTH_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH        = 34,
  parameter int unsigned BUF_DEPTH         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_in,
  input  logic [ADDR_WIDTH-1:0]        base_addr_in,
  input  logic [15:0]                  dest_id_in,
  input  logic [15:0]                  src_id_in,
  input  logic [DATA_LENGTH_WIDTH-1:0] len_in,
  input  logic [DATA_WIDTH-1:0]        s_tdata,
  input  logic [7:0]                   s_tkeep,
  input  logic                         s_tvalid,
  input  logic                         s_tlast,
  output logic                         s_tready,
  output logic [DATA_WIDTH-1:0]        ireq_tdata,
  output logic [7:0]                   ireq_tkeep,
  output logic                         ireq_tvalid,
  output logic                         ireq_tlast,
  output logic [31:0]                  ireq_tuser,
  input  logic                         ireq_tready,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RemW = DATA_LENGTH_WIDTH + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StHdr  = 2'd2;
  localparam logic [1:0] StData = 2'd3;

  localparam logic [CntW-1:0] LastBeat = CntW'(BUF_DEPTH - 1);

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             tid_q, tid_d;
  logic [RemW-1:0]        rem_q, rem_d;
  logic [15:0]            src_q, src_d;
  logic [15:0]            dest_q, dest_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [8:0]             byte_cnt_q, byte_cnt_d;
  logic [PtrW-1:0]        rd_cnt_q, rd_cnt_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  pkt_buf_q [BUF_DEPTH];

  logic [3:0]             keep_bytes;
  logic                   data_last;
  logic [7:0]             hdr_size;
  logic [RemW-1:0]        rem_after;

  // Number of valid byte lanes in the incoming beat.
  always_comb begin
    keep_bytes = 4'd0;
    for (int i = 0; i < 8; i++) begin
      keep_bytes = keep_bytes + {3'b000, s_tkeep[i]};
    end
  end

  assign data_last = ({1'b0, rd_cnt_q} == (beat_cnt_q - CntW'(1)));
  // 256 B wraps to 0 in the low byte, so minus one yields 8'hFF as required.
  assign hdr_size  = byte_cnt_q[7:0] - 8'd1;
  // Remaining count saturates at zero if the final packet overshoots the length.
  assign rem_after = (rem_q > RemW'(byte_cnt_q)) ? (rem_q - RemW'(byte_cnt_q)) : '0;

  // Next-state logic for the FSM and transfer bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tid_d      = tid_q;
    rem_d      = rem_q;
    src_d      = src_q;
    dest_d     = dest_q;
    beat_cnt_d = beat_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          addr_d  = base_addr_in;
          dest_d  = dest_id_in;
          src_d   = src_id_in;
          rem_d   = RemW'(len_in) + RemW'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (s_tvalid) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          byte_cnt_d = byte_cnt_q + 9'(keep_bytes);
          // A full buffer closes the packet even without tlast.
          if (s_tlast || (beat_cnt_q == LastBeat)) begin
            state_d = StHdr;
          end
        end
      end
      StHdr: begin
        if (ireq_tready) begin
          rd_cnt_d = '0;
          state_d  = StData;
        end
      end
      StData: begin
        if (ireq_tready) begin
          if (data_last) begin
            addr_d     = addr_q + ADDR_WIDTH'(byte_cnt_q);
            tid_d      = tid_q + 8'd1;
            rem_d      = rem_after;
            beat_cnt_d = '0;
            byte_cnt_d = '0;
            rd_cnt_d   = '0;
            if (rem_after != '0) begin
              state_d = StLoad;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            rd_cnt_d = rd_cnt_q + PtrW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      tid_q      <= '0;
      rem_q      <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      beat_cnt_q <= '0;
      byte_cnt_q <= '0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tid_q      <= tid_d;
      rem_q      <= rem_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      beat_cnt_q <= beat_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      done_q     <= done_d;
    end
  end

  // Packet buffer write; contents are don't-care outside a loaded packet.
  always_ff @(posedge clk) begin
    if ((state_q == StLoad) && s_tvalid) begin
      pkt_buf_q[beat_cnt_q[PtrW-1:0]] <= s_tdata;
    end
  end

  // Output decode; all outputs depend only on registered state, never on ireq_tready.
  always_comb begin
    s_tready    = (state_q == StLoad);
    ireq_tvalid = (state_q == StHdr) || (state_q == StData);
    ireq_tlast  = (state_q == StData) && data_last;
    ireq_tkeep  = ireq_tvalid ? 8'hFF : 8'h00;
    ireq_tuser  = {src_q, dest_q};
    busy_o      = (state_q != StIdle);
    done_o      = done_q;
    ireq_tdata  = '0;
    if (state_q == StHdr) begin
      ireq_tdata = {tid_q, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, hdr_size, 2'b00, addr_q};
    end else if (state_q == StData) begin
      ireq_tdata = pkt_buf_q[rd_cnt_q];
    end
  end

endmodule
